// File: rtl/fir_seq_ctrl_if.sv
// Stream bundle for fir_seq_ctrl: sample input (ss_*) and result output (sm_*).
// The controller takes the slave view: it consumes ss_* and produces sm_*.
// The wrapper or bench takes the master view.
interface fir_seq_ctrl_if #(
    parameter int unsigned DW = 32
) ();
    logic          ss_tvalid;
    logic [DW-1:0] ss_tdata;
    logic          ss_tlast;
    logic          ss_tready;
    logic          sm_tvalid;
    logic [DW-1:0] sm_tdata;
    logic          sm_tlast;
    logic          sm_tready;

    modport slave (
        input  ss_tvalid, ss_tdata, ss_tlast, sm_tready,
        output ss_tready, sm_tvalid, sm_tdata, sm_tlast
    );

    modport master (
        output ss_tvalid, ss_tdata, ss_tlast, sm_tready,
        input  ss_tready, sm_tvalid, sm_tdata, sm_tlast
    );
endinterface

// File: rtl/fir_seq_ctrl.sv
// Sequencer for an NUM_TAP-tap FIR MAC datapath. Samples arrive on the stream
// interface, are stored in a single-port data RAM used as a ring buffer, and each
// sample triggers an NUM_TAP-read MAC pass producing one output sample.
// Optional: define FIR_TLAST_CHECK_EN to flag ss_tlast disagreeing with the run length
// on the sticky err_tlast output; otherwise ss_tlast is ignored and err_tlast is 0.
module fir_seq_ctrl #(
    parameter int unsigned NUM_TAP = 11,
    parameter int unsigned DW      = 32,
    parameter int unsigned AW      = 4
) (
    input  logic                 CLK,
    input  logic                 Reset,
    input  logic                 ap_start,
    output logic                 ap_idle,
    output logic                 ap_done,
    input  logic [31:0]          data_length,
    fir_seq_ctrl_if.slave        axis,
    output logic [AW-1:0]        tap_A,
    input  logic [DW-1:0]        tap_Do,
    output logic                 data_WE,
    output logic [AW-1:0]        data_A,
    output logic [DW-1:0]        data_Di,
    input  logic [DW-1:0]        data_Do,
    output logic                 err_tlast
);

    typedef enum logic [2:0] {
        StIdle, StClr, StWaitIn, StWrite, StCalc, StOut, StDone
    } state_e;

    // Index counter is one bit wider than the address so it can reach NUM_TAP.
    localparam logic [AW:0]   NumTapIdx = (AW+1)'(NUM_TAP);
    localparam logic [AW:0]   LastIdx   = (AW+1)'(NUM_TAP - 1);
    localparam logic [AW-1:0] LastPtr   = AW'(NUM_TAP - 1);

    state_e        state_q, state_d;
    logic [31:0]   len_q, len_d;
    logic [31:0]   count_q, count_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW:0]   idx_q, idx_d;
    logic [DW-1:0] acc_q, acc_d;
    logic [DW-1:0] sample_q, sample_d;

    logic [DW-1:0] prod;
    logic [AW:0]   ring_sum;
    logic [AW-1:0] ring_addr;

    // Product of the RAM words addressed on the previous CALC cycle.
    assign prod = tap_Do * data_Do;

    // Tap k pairs with the sample written k inputs ago: (wptr + NUM_TAP - k) mod NUM_TAP.
    assign ring_sum  = {1'b0, wptr_q} + NumTapIdx - idx_q;
    assign ring_addr = (ring_sum >= NumTapIdx) ? AW'(ring_sum - NumTapIdx) : ring_sum[AW-1:0];

    assign axis.sm_tdata = acc_q;
    assign axis.sm_tlast = (state_q == StOut) && (count_q == len_q);

    // Next-state, datapath updates and control outputs.
    always_comb begin
        state_d        = state_q;
        len_d          = len_q;
        count_d        = count_q;
        wptr_d         = wptr_q;
        idx_d          = idx_q;
        acc_d          = acc_q;
        sample_d       = sample_q;
        ap_idle        = 1'b0;
        ap_done        = 1'b0;
        axis.ss_tready = 1'b0;
        axis.sm_tvalid = 1'b0;
        tap_A          = '0;
        data_WE        = 1'b0;
        data_A         = '0;
        data_Di        = '0;
        unique case (state_q)
            StIdle: begin
                ap_idle = 1'b1;
                if (ap_start) begin
                    len_d   = data_length;
                    count_d = '0;
                    wptr_d  = '0;
                    idx_d   = '0;
                    acc_d   = '0;
                    state_d = StClr;
                end
            end
            StClr: begin
                data_WE = 1'b1;
                data_A  = idx_q[AW-1:0];
                if (idx_q == LastIdx) begin
                    idx_d   = '0;
                    state_d = (len_q == 32'd0) ? StDone : StWaitIn;
                end else begin
                    idx_d = idx_q + (AW+1)'(1);
                end
            end
            StWaitIn: begin
                axis.ss_tready = 1'b1;
                if (axis.ss_tvalid) begin
                    sample_d = axis.ss_tdata;
                    state_d  = StWrite;
                end
            end
            StWrite: begin
                data_WE = 1'b1;
                data_A  = wptr_q;
                data_Di = sample_q;
                idx_d   = '0;
                state_d = StCalc;
            end
            StCalc: begin
                if (idx_q < NumTapIdx) begin
                    tap_A  = idx_q[AW-1:0];
                    data_A = ring_addr;
                end
                // RAM latency: the product for index k lands while idx is k+1.
                if (idx_q == (AW+1)'(1)) begin
                    acc_d = prod;
                end else if (idx_q != '0) begin
                    acc_d = acc_q + prod;
                end
                if (idx_q == NumTapIdx) begin
                    wptr_d  = (wptr_q == LastPtr) ? '0 : wptr_q + AW'(1);
                    count_d = count_q + 32'd1;
                    idx_d   = '0;
                    state_d = StOut;
                end else begin
                    idx_d = idx_q + (AW+1)'(1);
                end
            end
            StOut: begin
                axis.sm_tvalid = 1'b1;
                if (axis.sm_tready) begin
                    state_d = axis.sm_tlast ? StDone : StWaitIn;
                end
            end
            StDone: begin
                ap_done = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q  <= StIdle;
            len_q    <= '0;
            count_q  <= '0;
            wptr_q   <= '0;
            idx_q    <= '0;
            acc_q    <= '0;
            sample_q <= '0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            count_q  <= count_d;
            wptr_q   <= wptr_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            sample_q <= sample_d;
        end
    end

`ifdef FIR_TLAST_CHECK_EN
    logic err_q, err_d;

    // Sticky flag: ss_tlast must be set exactly on the sample that completes the run.
    always_comb begin
        err_d = err_q;
        if ((state_q == StIdle) && ap_start) begin
            err_d = 1'b0;
        end else if (axis.ss_tvalid && axis.ss_tready) begin
            if (axis.ss_tlast != ((count_q + 32'd1) == len_q)) begin
                err_d = 1'b1;
            end
        end
    end

    // Error flag register.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_tlast = err_q;
`else
    logic unused_tlast;
    assign unused_tlast = axis.ss_tlast;
    assign err_tlast    = 1'b0;
`endif

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Directed self-checking bench for fir_seq_ctrl with behavioural tap/data RAMs.
module tb_fir_seq_ctrl;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        ap_start;
    logic        ap_idle;
    logic        ap_done;
    logic [31:0] data_length;
    logic [3:0]  tap_A;
    logic [31:0] tap_Do;
    logic        data_WE;
    logic [3:0]  data_A;
    logic [31:0] data_Di;
    logic [31:0] data_Do;
    logic        err_tlast;
    logic        poison;

    int checks   = 0;
    int failures = 0;

    logic [31:0] tap_mem  [16];
    logic [31:0] data_mem [16];

    fir_seq_ctrl_if #(.DW(32)) axis ();

    fir_seq_ctrl #(.NUM_TAP(11), .DW(32), .AW(4)) dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .ap_start    (ap_start),
        .ap_idle     (ap_idle),
        .ap_done     (ap_done),
        .data_length (data_length),
        .axis        (axis),
        .tap_A       (tap_A),
        .tap_Do      (tap_Do),
        .data_WE     (data_WE),
        .data_A      (data_A),
        .data_Di     (data_Di),
        .data_Do     (data_Do),
        .err_tlast   (err_tlast)
    );

    always #5 CLK = ~CLK;

    // Synchronous-read RAMs; poison fills the data RAM with junk so CLR is observable.
    always @(posedge CLK) begin
        tap_Do <= tap_mem[tap_A];
        if (poison) begin
            for (int i = 0; i < 16; i++) data_mem[i] <= 32'hDEAD_BEEF;
        end else if (data_WE) begin
            data_mem[data_A] <= data_Di;
        end
        data_Do <= data_mem[data_A];
    end

    task automatic set_taps(input logic [31:0] v);
        for (int i = 0; i < 16; i++) tap_mem[i] = v;
    endtask

    // Called at a negedge with the DUT idle.
    task automatic start_run(input logic [31:0] len);
        ap_start    = 1'b1;
        data_length = len;
        @(negedge CLK);
        ap_start    = 1'b0;
        data_length = 32'd999;
    endtask

    // Returns at the negedge following the handshake cycle.
    task automatic send_sample(input logic [31:0] d, input logic l, output bit ok);
        int n;
        ok = 1'b0;
        n  = 0;
        axis.ss_tvalid = 1'b1;
        axis.ss_tdata  = d;
        axis.ss_tlast  = l;
        while (!ok && n < 200) begin
            if (axis.ss_tready) ok = 1'b1;
            @(negedge CLK);
            n++;
        end
        axis.ss_tvalid = 1'b0;
        axis.ss_tlast  = 1'b0;
    endtask

    task automatic recv_output(output logic [31:0] d, output logic l, output bit ok);
        int n;
        ok = 1'b0;
        n  = 0;
        d  = '0;
        l  = 1'b0;
        axis.sm_tready = 1'b1;
        while (!ok && n < 200) begin
            if (axis.sm_tvalid) begin
                ok = 1'b1;
                d  = axis.sm_tdata;
                l  = axis.sm_tlast;
            end
            @(negedge CLK);
            n++;
        end
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        #1;
        checks++;
        if (ap_idle !== 1'b1 || ap_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_ap: idle=%b done=%b expected 1 0", ap_idle, ap_done);
        end
        checks++;
        if (axis.ss_tready !== 1'b0 || axis.sm_tvalid !== 1'b0 || axis.sm_tlast !== 1'b0) begin
            failures++;
            $display("FAIL reset_stream: tready=%b tvalid=%b tlast=%b expected 0 0 0",
                     axis.ss_tready, axis.sm_tvalid, axis.sm_tlast);
        end
        checks++;
        if (data_WE !== 1'b0 || data_A !== 4'd0 || data_Di !== 32'd0 || tap_A !== 4'd0) begin
            failures++;
            $display("FAIL reset_ram: we=%b dA=%0d di=%0h tA=%0d expected 0 0 0 0",
                     data_WE, data_A, data_Di, tap_A);
        end
        checks++;
        if (axis.sm_tdata !== 32'd0 || err_tlast !== 1'b0) begin
            failures++;
            $display("FAIL reset_data: tdata=%0h err=%b expected 0 0", axis.sm_tdata, err_tlast);
        end
        @(negedge CLK);
        Reset = 1'b0;
        @(negedge CLK);
        checks++;
        if (ap_idle !== 1'b1 || axis.ss_tready !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: idle=%b tready=%b expected 1 0", ap_idle, axis.ss_tready);
        end
    endtask

    task automatic test_impulse;
        logic [31:0] y;
        logic        l;
        bit          ok;
        for (int i = 0; i < 16; i++) tap_mem[i] = i;
        start_run(32'd11);
        for (int n = 0; n < 11; n++) begin
            send_sample((n == 0) ? 32'd1 : 32'd0, n == 10, ok);
            recv_output(y, l, ok);
            checks++;
            if (!ok || y !== n || l !== (n == 10)) begin
                failures++;
                $display("FAIL impulse_y%0d: got %0d last=%b ok=%b expected %0d last=%b",
                         n, y, l, ok, n, n == 10);
            end
        end
        checks++;
        if (ap_done !== 1'b1) begin
            failures++;
            $display("FAIL impulse_done: ap_done=%b expected 1", ap_done);
        end
        @(negedge CLK);
        checks++;
        if (ap_done !== 1'b0 || ap_idle !== 1'b1) begin
            failures++;
            $display("FAIL impulse_idle: done=%b idle=%b expected 0 1", ap_done, ap_idle);
        end
    endtask

    task automatic test_running_sum;
        logic [31:0] exp_y [15];
        logic [31:0] y;
        logic        l;
        bit          ok;
        exp_y = '{1, 3, 6, 10, 15, 21, 28, 36, 45, 55, 66, 77, 88, 99, 110};
        set_taps(32'd1);
        start_run(32'd15);
        for (int n = 0; n < 15; n++) begin
            send_sample(n + 1, n == 14, ok);
            // A stray start mid-run must be ignored.
            if (n == 3) begin
                ap_start    = 1'b1;
                data_length = 32'd2;
            end
            recv_output(y, l, ok);
            ap_start = 1'b0;
            checks++;
            if (!ok || y !== exp_y[n] || l !== (n == 14)) begin
                failures++;
                $display("FAIL runsum_y%0d: got %0d last=%b ok=%b expected %0d last=%b",
                         n, y, l, ok, exp_y[n], n == 14);
            end
        end
        @(negedge CLK);
    endtask

    task automatic test_backpressure;
        logic [31:0] y;
        logic        l;
        bit          ok;
        int          cnt;
        set_taps(32'd1);
        axis.sm_tready = 1'b0;
        start_run(32'd2);
        send_sample(32'd7, 1'b0, ok);
        cnt = 1;
        while (!axis.sm_tvalid && cnt < 100) begin
            @(negedge CLK);
            cnt++;
        end
        checks++;
        if (cnt != 14) begin
            failures++;
            $display("FAIL latency: got %0d cycles expected 14", cnt);
        end
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (axis.sm_tvalid !== 1'b1 || axis.sm_tdata !== 32'd7 ||
                axis.ss_tready !== 1'b0 || axis.sm_tlast !== 1'b0) begin
                failures++;
                $display("FAIL stall_%0d: tvalid=%b tdata=%0d tready=%b tlast=%b expected 1 7 0 0",
                         i, axis.sm_tvalid, axis.sm_tdata, axis.ss_tready, axis.sm_tlast);
            end
            @(negedge CLK);
        end
        recv_output(y, l, ok);
        checks++;
        if (!ok || y !== 32'd7 || l !== 1'b0) begin
            failures++;
            $display("FAIL bp_y0: got %0d last=%b expected 7 last=0", y, l);
        end
        send_sample(32'd3, 1'b1, ok);
        recv_output(y, l, ok);
        checks++;
        if (!ok || y !== 32'd10 || l !== 1'b1) begin
            failures++;
            $display("FAIL bp_y1: got %0d last=%b expected 10 last=1", y, l);
        end
        @(negedge CLK);
    endtask

    task automatic test_restart;
        logic [31:0] y;
        logic        l;
        bit          ok;
        set_taps(32'd1);
        start_run(32'd11);
        for (int n = 0; n < 11; n++) begin
            send_sample(32'd5, n == 10, ok);
            recv_output(y, l, ok);
            checks++;
            if (!ok || y !== 5 * (n + 1)) begin
                failures++;
                $display("FAIL restart_run1_y%0d: got %0d expected %0d", n, y, 5 * (n + 1));
            end
        end
        @(negedge CLK);
        start_run(32'd1);
        send_sample(32'd1, 1'b1, ok);
        recv_output(y, l, ok);
        checks++;
        if (!ok || y !== 32'd1 || l !== 1'b1) begin
            failures++;
            $display("FAIL restart_run2: got %0d last=%b expected 1 last=1", y, l);
        end
        @(negedge CLK);
    endtask

    task automatic test_overflow;
        logic [31:0] y;
        logic        l;
        bit          ok;
        set_taps(32'd0);
        tap_mem[0] = 32'hFFFF_FFFF;
        start_run(32'd1);
        send_sample(32'd2, 1'b1, ok);
        recv_output(y, l, ok);
        checks++;
        if (!ok || y !== 32'hFFFF_FFFE) begin
            failures++;
            $display("FAIL overflow_prod: got %0h expected fffffffe", y);
        end
        @(negedge CLK);
        set_taps(32'h8000_0000);
        start_run(32'd2);
        send_sample(32'd1, 1'b0, ok);
        recv_output(y, l, ok);
        checks++;
        if (!ok || y !== 32'h8000_0000) begin
            failures++;
            $display("FAIL overflow_acc0: got %0h expected 80000000", y);
        end
        send_sample(32'd1, 1'b1, ok);
        recv_output(y, l, ok);
        checks++;
        if (!ok || y !== 32'h0 || l !== 1'b1) begin
            failures++;
            $display("FAIL overflow_wrap: got %0h last=%b expected 0 last=1", y, l);
        end
        @(negedge CLK);
    endtask

    task automatic test_reset_mid_calc;
        logic [31:0] y;
        logic [31:0] exp_y [5];
        logic        l;
        logic        exp_err;
        bit          ok;
        bit          seen;
        exp_y = '{1, 3, 6, 10, 15};
        set_taps(32'd1);
        start_run(32'd5);
        send_sample(32'd9, 1'b0, ok);
        repeat (4) @(negedge CLK);
        #2;
        Reset = 1'b1;
        #1;
        checks++;
        if (ap_idle !== 1'b1 || axis.sm_tvalid !== 1'b0 || axis.ss_tready !== 1'b0 ||
            tap_A !== 4'd0 || data_A !== 4'd0 || axis.sm_tdata !== 32'd0) begin
            failures++;
            $display("FAIL midcalc_reset: idle=%b tvalid=%b tready=%b tA=%0d dA=%0d tdata=%0h exp 1 0 0 0 0 0",
                     ap_idle, axis.sm_tvalid, axis.ss_tready, tap_A, data_A, axis.sm_tdata);
        end
        @(negedge CLK);
        Reset = 1'b0;
        seen  = 1'b0;
        repeat (20) begin
            @(negedge CLK);
            if (axis.sm_tvalid || !ap_idle) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL midcalc_quiet: activity after reset seen=1 expected 0");
        end
        start_run(32'd5);
        for (int n = 0; n < 5; n++) begin
            send_sample(n + 1, (n == 2) || (n == 4), ok);
`ifdef FIR_TLAST_CHECK_EN
            exp_err = (n >= 2);
`else
            exp_err = 1'b0;
`endif
            checks++;
            if (!ok || err_tlast !== exp_err) begin
                failures++;
                $display("FAIL tlast_err_s%0d: err=%b expected %b", n, err_tlast, exp_err);
            end
            recv_output(y, l, ok);
            checks++;
            if (!ok || y !== exp_y[n] || l !== (n == 4)) begin
                failures++;
                $display("FAIL midcalc_y%0d: got %0d last=%b expected %0d last=%b",
                         n, y, l, exp_y[n], n == 4);
            end
        end
        @(negedge CLK);
    endtask

    task automatic test_zero_length;
        int cnt;
        bit seen;
        bit dirty;
        ap_start    = 1'b1;
        data_length = 32'd0;
        cnt  = 0;
        seen = 1'b0;
        while (!ap_done && cnt < 100) begin
            @(negedge CLK);
            cnt++;
            ap_start    = 1'b0;
            data_length = 32'd999;
            if (axis.sm_tvalid || axis.ss_tready) seen = 1'b1;
        end
        checks++;
        if (cnt != 12) begin
            failures++;
            $display("FAIL zero_len_done: got %0d cycles expected 12", cnt);
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL zero_len_stream: stream activity seen=1 expected 0");
        end
        checks++;
        if (err_tlast !== 1'b0) begin
            failures++;
            $display("FAIL zero_len_err_clear: err=%b expected 0", err_tlast);
        end
        dirty = 1'b0;
        for (int i = 0; i < 11; i++) if (data_mem[i] !== 32'd0) dirty = 1'b1;
        checks++;
        if (dirty) begin
            failures++;
            $display("FAIL clr_history: nonzero entry found=1 expected 0");
        end
        @(negedge CLK);
        checks++;
        if (ap_idle !== 1'b1 || ap_done !== 1'b0) begin
            failures++;
            $display("FAIL zero_len_idle: idle=%b done=%b expected 1 0", ap_idle, ap_done);
        end
    endtask

    initial begin
        Reset          = 1'b0;
        poison         = 1'b1;
        ap_start       = 1'b0;
        data_length    = 32'd0;
        axis.ss_tvalid = 1'b0;
        axis.ss_tdata  = 32'd0;
        axis.ss_tlast  = 1'b0;
        axis.sm_tready = 1'b1;
        set_taps(32'd0);
        #2;
        test_reset;
        poison = 1'b0;
        test_impulse;
        test_running_sum;
        test_backpressure;
        test_restart;
        test_overflow;
        test_reset_mid_calc;
        test_zero_length;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
